execute_cycle: RTL and testbench
================================

Name: execute_cycle

Overview:
- EX stage of the 5-stage RV32 pipeline; sits directly upstream of the memory stage and drives its inputs.
- Contains three pieces:
  - operand forwarding muxes;
  - a single-cycle ALU plus an iterative 32-cycle shift-add multiplier (MUL) that stalls the front end;
  - branch/jump resolution.
- Terminates in the EX/MEM pipeline register.

Parameters:
- MUL_CYCLES, 32, number of BUSY iterations of the multiplier (one bit per cycle; must equal 32).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- RegWriteE  in  1  register-write enable of the instruction in EX
- MemWriteE  in  1  store enable
- ResultSrcE  in  2  writeback select, passed through
- BranchE  in  1  conditional branch (beq)
- JumpE  in  1  unconditional jump
- MulE  in  1  instruction is a multiply
- ALUSrcE  in  1  0 = SrcB from forwarded RD2, 1 = Imm_Ext_E
- ALUControlE  in  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed); 110 = high-half multiply (only with optional feature)
- RD1_E, RD2_E  in  32  register-file operands
- Imm_Ext_E  in  32  sign-extended immediate
- RD_E  in  5  destination register
- PCE, PCPlus4E  in  32  PC and PC+4 of the instruction
- ForwardAE, ForwardBE  in  2  00 = RDx_E, 01 = ResultW, 10 = ALU_ResultM
- ResultW  in  32  writeback-stage result, for forwarding
- PCSrcE  out  1  redirect fetch to PCTargetE
- PCTargetE  out  32  PCE + Imm_Ext_E
- StallE  out  1  hold IF/ID/EX, multiply in progress
- RegWriteM, MemWriteM  out  1  EX/MEM registered controls
- ResultSrcM  out  2  registered
- RD_M  out  5  registered
- PCPlus4M, WriteDataM, ALU_ResultM  out  32  registered

Behaviour:
- Reset: asynchronous, active-high, immediate.
  - All *M outputs go to 0.
  - FSM goes to IDLE; counter and accumulators go to 0.
  - A multiply in progress is discarded; no partial result ever reaches the EX/MEM register.
- Forwarding:
  - SrcA = mux(ForwardAE).
  - WriteDataE = mux(ForwardBE).
  - SrcB = ALUSrcE ? Imm_Ext_E : WriteDataE.
  - Code 11 behaves as 00.
- ALU: combinational, 32-bit wrap-around arithmetic.
  - slt produces 1/0 from a signed compare.
  - ZeroE = (ALU result == 0), computed from the sub result.
- Branch resolution: combinational.
  - PCSrcE = JumpE | (BranchE & ZeroE).
  - PCSrcE is forced 0 while StallE = 1.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE, MulE = 1: latch SrcA/SrcB, clear accumulator, counter = 0, go to BUSY.
  - BUSY: each cycle, if multiplier bit0 = 1, add multiplicand; shift multiplicand left and multiplier right; counter++. After the MUL_CYCLES-th iteration go to DONE.
  - DONE: go to IDLE unconditionally. MulE is still high in this cycle because upstream is held; it must not restart the FSM.
- StallE = (IDLE & MulE) | BUSY.
- EX/MEM register, updated every cycle unless reset:
  - StallE = 1: insert a bubble. RegWriteM = 0, MemWriteM = 0, other M fields hold their previous values.
  - DONE: capture the control inputs; ALU_ResultM = product[31:0].
  - Otherwise (IDLE, MulE = 0): capture the control inputs and the ALU result.
- Multiply latency: 34 cycles in EX, i.e. 1 accept + 32 BUSY + 1 DONE. 33 bubbles are emitted; the result appears in ALU_ResultM one edge after DONE.
- Back-to-back MULs: the second MUL is seen in IDLE on the cycle after DONE and starts normally.

Optional Feature:
- Macro: EXEC_MULH_EN.
- Defined:
  - The accumulator is 64-bit, unsigned.
  - MulE = 1 with ALUControlE = 110 returns product[63:32] (MULHU); any other ALUControlE returns [31:0].
- Undefined:
  - The accumulator is 32-bit.
  - ALUControlE is ignored when MulE = 1; the low half is always returned.

Test Plan:
- rst held with MulE = 1, then released → all *M outputs = 0; StallE = 1 from the first cycle after release; FSM leaves IDLE on the first edge.
- add, RD1 = 7, Imm = 5, ALUSrcE = 1, RegWriteE = 1, RD_E = 3 → next edge: ALU_ResultM = 12, RD_M = 3, RegWriteM = 1.
- ForwardAE = 10 with ALU_ResultM = 0x10, ForwardBE = 01 with ResultW = 0x3, sub → ALU_ResultM = 0xD, WriteDataM = 0x3.
- beq with SrcA = SrcB = 9, PCE = 0x40, Imm = 0x8 → PCSrcE = 1, PCTargetE = 0x48. Same case with SrcB = 8 → PCSrcE = 0.
- MUL 0xFFFF_FFFF × 3 → StallE high for exactly 33 cycles, 33 bubbles with RegWriteM = 0, then ALU_ResultM = 0xFFFF_FFFD. With EXEC_MULH_EN and ALUControlE = 110 → ALU_ResultM = 0x0000_0002.
- rst pulsed at BUSY cycle 10 of a MUL → outputs = 0, StallE = 0 if MulE = 0, no product ever written; a following add completes normally.

Source files
------------

// File: rtl/execute_cycle.sv
// EX stage of the RV32 pipeline: operand forwarding, ALU, iterative shift-add multiplier,
// branch resolution and the EX/MEM register. Define EXEC_MULH_EN to add MULHU (ALUControlE = 110).
module execute_cycle #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic [1:0]  ResultSrcE,
    input  logic        BranchE,
    input  logic        JumpE,
    input  logic        MulE,
    input  logic        ALUSrcE,
    input  logic [2:0]  ALUControlE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [4:0]  RD_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic [31:0] ResultW,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        StallE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic [1:0]  ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] PCPlus4M,
    output logic [31:0] WriteDataM,
    output logic [31:0] ALU_ResultM
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_BUSY = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam int CNT_W = $clog2(MUL_CYCLES) + 1;

`ifdef EXEC_MULH_EN
    localparam int ACC_W = 64;
`else
    localparam int ACC_W = 32;
`endif

    logic [31:0]      src_a;
    logic [31:0]      src_b;
    logic [31:0]      write_data;
    logic [31:0]      sub_res;
    logic [31:0]      alu_res;
    logic [31:0]      mul_res;
    logic             zero;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] mcand;
    logic [ACC_W-1:0] acc;
    logic [31:0]      mplier;

    // Forwarding; code 11 falls back to the register-file operand.
    always_comb begin
        src_a = RD1_E;
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALU_ResultM;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        write_data = RD2_E;
        case (ForwardBE)
            2'b01:   write_data = ResultW;
            2'b10:   write_data = ALU_ResultM;
            default: write_data = RD2_E;
        endcase
    end

    assign src_b   = ALUSrcE ? Imm_Ext_E : write_data;
    assign sub_res = src_a - src_b;
    assign zero    = (sub_res == 32'd0);

    always_comb begin
        alu_res = 32'd0;
        case (ALUControlE)
            3'b000:  alu_res = src_a + src_b;
            3'b001:  alu_res = sub_res;
            3'b010:  alu_res = src_a & src_b;
            3'b011:  alu_res = src_a | src_b;
            3'b100:  alu_res = src_a ^ src_b;
            3'b101:  alu_res = {31'd0, $signed(src_a) < $signed(src_b)};
            default: alu_res = 32'd0;
        endcase
    end

    assign StallE    = ((state == S_IDLE) && MulE) || (state == S_BUSY);
    assign PCSrcE    = (JumpE || (BranchE && zero)) && !StallE;
    assign PCTargetE = PCE + Imm_Ext_E;

    // Shift-add multiplier: one multiplier bit per BUSY cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (MulE) begin
                        mcand  <= ACC_W'(src_a);
                        mplier <= src_b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(MUL_CYCLES - 1))
                        state <= S_DONE;
                end
                // MulE is still high here because upstream was held; do not restart.
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef EXEC_MULH_EN
    assign mul_res = (ALUControlE == 3'b110) ? acc[63:32] : acc[31:0];
`else
    assign mul_res = acc[31:0];
`endif

    // EX/MEM register; a stall inserts a bubble and holds the data fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 2'b00;
            RD_M        <= 5'd0;
            PCPlus4M    <= 32'd0;
            WriteDataM  <= 32'd0;
            ALU_ResultM <= 32'd0;
        end else if (StallE) begin
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
        end else begin
            RegWriteM   <= RegWriteE;
            MemWriteM   <= MemWriteE;
            ResultSrcM  <= ResultSrcE;
            RD_M        <= RD_E;
            PCPlus4M    <= PCPlus4E;
            WriteDataM  <= write_data;
            ALU_ResultM <= (state == S_DONE) ? mul_res : alu_res;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Randomized self-checking bench for execute_cycle against a behavioural EX-stage model.
module tb_execute_cycle;

    logic        clk, rst;
    logic        RegWriteE, MemWriteE, BranchE, JumpE, MulE, ALUSrcE;
    logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic        PCSrcE, StallE, RegWriteM, MemWriteM;
    logic [31:0] PCTargetE, PCPlus4M, WriteDataM, ALU_ResultM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RD_M;

    int n_chk = 0;
    int n_pass = 0;

    // model of the EX/MEM register contents
    logic        m_rw, m_mw;
    logic [1:0]  m_rs;
    logic [4:0]  m_rd;
    logic [31:0] m_pc4, m_wd, m_alu;

    execute_cycle #(.MUL_CYCLES(32)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .BranchE(BranchE), .JumpE(JumpE), .MulE(MulE), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
        .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ForwardAE(ForwardAE),
        .ForwardBE(ForwardBE), .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .StallE(StallE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
        .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] fwd(input logic [1:0] code, input logic [31:0] rd,
                                        input logic [31:0] resw, input logic [31:0] alum);
        if (code == 2'b01) return resw;
        if (code == 2'b10) return alum;
        return rd;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] src_a_ref();
        return fwd(ForwardAE, RD1_E, ResultW, m_alu);
    endfunction

    function automatic logic [31:0] src_b_ref();
        return ALUSrcE ? Imm_Ext_E : fwd(ForwardBE, RD2_E, ResultW, m_alu);
    endfunction

    // Model capture of a non-multiply instruction at the coming edge.
    task automatic model_step();
        logic [31:0] r, w;
        r = alu_ref(ALUControlE, src_a_ref(), src_b_ref());
        w = fwd(ForwardBE, RD2_E, ResultW, m_alu);
        m_rw = RegWriteE; m_mw = MemWriteE; m_rs = ResultSrcE; m_rd = RD_E;
        m_pc4 = PCPlus4E; m_wd = w; m_alu = r;
    endtask

    task automatic model_reset();
        m_rw = 0; m_mw = 0; m_rs = 0; m_rd = 0; m_pc4 = 0; m_wd = 0; m_alu = 0;
    endtask

    task automatic idle_inputs();
        RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0; JumpE = 0; MulE = 0;
        ALUSrcE = 0; ALUControlE = 0; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; RD_E = 0;
        PCE = 0; PCPlus4E = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; MulE = 1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM} !== '0)
            $display("FAIL reset_m_outputs got %h want 0",
                     {RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM});
        else n_pass++;
        rst = 0;
        #1;
        n_chk++;
        if (StallE !== 1'b1) $display("FAIL reset_release_stall got %b want 1", StallE);
        else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if (StallE !== 1'b1 || RegWriteM !== 1'b0 || ALU_ResultM !== 32'd0)
            $display("FAIL reset_first_edge_busy stall=%b rw=%b alu=%h want 1 0 0",
                     StallE, RegWriteM, ALU_ResultM);
        else n_pass++;
        rst = 1; MulE = 0;
        #1 rst = 0;
        model_reset();
    endtask

    task automatic test_alu_add();
        idle_inputs();
        RD1_E = 7; Imm_Ext_E = 5; ALUSrcE = 1; RegWriteE = 1; RD_E = 3; PCPlus4E = 32'h104;
        model_step();
        @(posedge clk); #1;
        n_chk++;
        if (ALU_ResultM !== 32'd12 || RD_M !== 5'd3 || RegWriteM !== 1'b1)
            $display("FAIL add_7_5 got alu=%0d rd=%0d rw=%b want 12 3 1", ALU_ResultM, RD_M, RegWriteM);
        else n_pass++;
    endtask

    task automatic test_forward();
        idle_inputs();
        RD1_E = 32'h10; ALUSrcE = 1; RegWriteE = 1; RD_E = 4;
        model_step();
        @(posedge clk); #1;
        ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'h3; ALUControlE = 3'd1; ALUSrcE = 0;
        RD1_E = 32'hdead; RD2_E = 32'hbeef;
        model_step();
        @(posedge clk); #1;
        n_chk++;
        if (ALU_ResultM !== 32'hD || WriteDataM !== 32'h3)
            $display("FAIL forward_sub got alu=%h wd=%h want d 3", ALU_ResultM, WriteDataM);
        else n_pass++;
    endtask

    task automatic test_branch();
        idle_inputs();
        BranchE = 1; ALUControlE = 3'd1; RD1_E = 9; RD2_E = 9; PCE = 32'h40; Imm_Ext_E = 32'h8;
        #1;
        n_chk++;
        if (PCSrcE !== 1'b1 || PCTargetE !== 32'h48)
            $display("FAIL beq_taken got pcsrc=%b tgt=%h want 1 48", PCSrcE, PCTargetE);
        else n_pass++;
        RD2_E = 8;
        #1;
        n_chk++;
        if (PCSrcE !== 1'b0) $display("FAIL beq_not_taken got pcsrc=%b want 0", PCSrcE);
        else n_pass++;
        model_step();
        @(posedge clk); #1;
    endtask

    task automatic test_random_alu();
        logic [31:0] a, b;
        logic        exp_src;
        for (int i = 0; i < 200; i++) begin
            RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); ResultSrcE = 2'($urandom);
            BranchE = 1'($urandom); JumpE = (($urandom % 5) == 0); MulE = 0;
            ALUSrcE = 1'($urandom); ALUControlE = 3'($urandom_range(0, 5));
            RD1_E = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            RD2_E = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            Imm_Ext_E = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            RD_E = 5'($urandom); PCE = $urandom; PCPlus4E = $urandom;
            ForwardAE = 2'($urandom); ForwardBE = 2'($urandom); ResultW = $urandom;
            #1;
            a = src_a_ref(); b = src_b_ref();
            exp_src = JumpE || (BranchE && (a == b));
            n_chk++;
            if (PCSrcE !== exp_src || PCTargetE !== PCE + Imm_Ext_E || StallE !== 1'b0)
                $display("FAIL rand_branch[%0d] got pcsrc=%b tgt=%h stall=%b want %b %h 0",
                         i, PCSrcE, PCTargetE, StallE, exp_src, PCE + Imm_Ext_E);
            else n_pass++;
            model_step();
            @(posedge clk); #1;
            n_chk++;
            if ({RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM} !==
                {m_rw, m_mw, m_rs, m_rd, m_pc4, m_wd, m_alu})
                $display("FAIL rand_exmem[%0d] got alu=%h wd=%h rd=%0d want alu=%h wd=%h rd=%0d",
                         i, ALU_ResultM, WriteDataM, RD_M, m_alu, m_wd, m_rd);
            else n_pass++;
        end
    endtask

    // Issues a multiply and follows it through DONE; MulE is left high for the caller.
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [63:0] prod;
        logic [31:0] exp;
        int stall_n, bub_n;
        idle_inputs();
        MulE = 1; ALUControlE = op; RD1_E = a; RD2_E = b; RegWriteE = 1; RD_E = 5'd9;
        PCPlus4E = $urandom; ResultSrcE = 2'b10;
        prod = {32'd0, a} * {32'd0, b};
`ifdef EXEC_MULH_EN
        exp = (op == 3'b110) ? prod[63:32] : prod[31:0];
`else
        exp = prod[31:0];
`endif
        #1;
        stall_n = StallE ? 1 : 0;
        bub_n = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (RegWriteM === 1'b0 && MemWriteM === 1'b0 &&
                {ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM} === {m_rs, m_rd, m_pc4, m_wd, m_alu})
                bub_n++;
            if (StallE !== 1'b1) break;
            stall_n++;
        end
        n_chk++;
        if (stall_n != 33) $display("FAIL mul_stall_cycles got %0d want 33", stall_n);
        else n_pass++;
        n_chk++;
        if (bub_n != 33) $display("FAIL mul_bubbles got %0d want 33", bub_n);
        else n_pass++;
        m_rw = 1; m_mw = 0; m_rs = 2'b10; m_rd = 5'd9; m_pc4 = PCPlus4E; m_wd = b; m_alu = exp;
        @(posedge clk); #1;
        n_chk++;
        if ({RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM} !==
            {m_rw, m_mw, m_rs, m_rd, m_pc4, m_wd, m_alu})
            $display("FAIL mul_result %h*%h op=%0d got alu=%h rw=%b want alu=%h rw=1",
                     a, b, op, ALU_ResultM, RegWriteM, exp);
        else n_pass++;
    endtask

    task automatic test_mul();
        do_mul(32'hFFFF_FFFF, 32'd3, 3'b000);
        MulE = 0;
        #1;
        n_chk++;
        if (StallE !== 1'b0) $display("FAIL mul_no_restart got stall=%b want 0", StallE);
        else n_pass++;
        do_mul(32'hFFFF_FFFF, 32'd3, 3'b110);
        MulE = 0;
        for (int i = 0; i < 3; i++) begin
            do_mul($urandom, $urandom, (i == 1) ? 3'b110 : 3'b000);
            MulE = 0;
        end
        #1;
    endtask

    task automatic test_back_to_back();
        do_mul(32'd12345, 32'd678, 3'b000);
        do_mul(32'h8000_0001, 32'hFFFF_FFFE, 3'b110);
        MulE = 0;
        #1;
        n_chk++;
        if (StallE !== 1'b0) $display("FAIL b2b_idle got stall=%b want 0", StallE);
        else n_pass++;
    endtask

    task automatic test_mul_reset();
        logic bad;
        idle_inputs();
        MulE = 1; JumpE = 1; RD1_E = 32'h1234; RD2_E = 32'h55; RegWriteE = 1; RD_E = 7;
        #1;
        n_chk++;
        if (PCSrcE !== 1'b0) $display("FAIL stall_blocks_jump got pcsrc=%b want 0", PCSrcE);
        else n_pass++;
        repeat (11) @(posedge clk);
        #1;
        rst = 1; MulE = 0; JumpE = 0; RegWriteE = 0; RD1_E = 0; RD2_E = 0; RD_E = 0;
        #1;
        n_chk++;
        if ({RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM} !== '0 ||
            StallE !== 1'b0)
            $display("FAIL mul_reset_outputs got alu=%h stall=%b want 0 0", ALU_ResultM, StallE);
        else n_pass++;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (ALU_ResultM !== 32'd0 || RegWriteM !== 1'b0 || StallE !== 1'b0) bad = 1;
        end
        n_chk++;
        if (bad) $display("FAIL mul_reset_no_product got alu=%h stall=%b want 0 0", ALU_ResultM, StallE);
        else n_pass++;
        test_alu_add();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alu_add();
        test_forward();
        test_branch();
        test_random_alu();
        test_mul();
        test_back_to_back();
        test_mul_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
